// File: rtl/apb_timer_slave_if.sv
// APB slave-side bus bundle for the timer: the bridge drives the request
// fields, the timer returns registered read data. No PREADY/PSLVERR.
interface apb_timer_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_slave.sv
// Prescaled down-counting timer behind a zero-wait-state APB port.
// LOAD/VALUE/CTRL/INTCLR/INTSTAT at word offsets 0x00..0x10; every other
// offset reads 0 and swallows writes. One level interrupt = INT_RAW & IE.
module apb_timer_slave #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 hclk,
  input  logic                 hrst_b,
  apb_timer_slave_if.slave     apb,
  output logic                 tim_int
);

  logic [CNT_WIDTH-1:0] r_load, r_value;
  logic                 r_en, r_oneshot, r_ie, r_int_raw;
  logic [7:0]           r_presc, r_pcnt;
  logic [31:0]          r_prdata;

  logic [9:0]  w_off;
  logic        w_wr, w_rd_setup;
  logic        w_wr_load, w_wr_ctrl, w_wr_intclr;
  logic        w_tick, w_expire;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_off       = apb.paddr[11:2];
  assign w_wr        = apb.psel & apb.penable & apb.pwrite;
  assign w_rd_setup  = apb.psel & ~apb.penable & ~apb.pwrite;
  assign w_wr_load   = w_wr & (w_off == 10'd0);
  assign w_wr_ctrl   = w_wr & (w_off == 10'd2);
  assign w_wr_intclr = w_wr & (w_off == 10'd3);

  // A LOAD write on the expiring tick suppresses decrement, reload, INT set
  // and one-shot auto-stop: the freshly written count takes over.
  assign w_tick   = r_en & (r_pcnt == r_presc);
  assign w_expire = w_tick & (r_value == '0) & ~w_wr_load;

  assign w_unused = &{1'b0, apb.paddr[1:0], apb.pwdata};

  // Read mux; only sampled on read setup cycles, narrow fields zero-extend.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      10'd0: w_rdata[CNT_WIDTH-1:0] = r_load;
      10'd1: w_rdata[CNT_WIDTH-1:0] = r_value;
      10'd2: w_rdata = {16'd0, r_presc, 5'd0, r_ie, r_oneshot, r_en};
      10'd4: w_rdata = {30'd0, r_int_raw & r_ie, r_int_raw};
      default: w_rdata = '0;
    endcase
  end

  // Registered read data, captured in the setup cycle, held otherwise.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b)         r_prdata <= '0;
    else if (w_rd_setup) r_prdata <= w_rdata;
  end

  // LOAD and CTRL; a CTRL write beats the one-shot auto-clear of EN.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      r_load    <= '0;
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_ie      <= 1'b0;
      r_presc   <= '0;
    end else begin
      if (w_wr_load) r_load <= apb.pwdata[CNT_WIDTH-1:0];
      if (w_wr_ctrl) begin
        r_en      <= apb.pwdata[0];
        r_oneshot <= apb.pwdata[1];
        r_ie      <= apb.pwdata[2];
        r_presc   <= apb.pwdata[15:8];
      end else if (w_expire && r_oneshot) begin
        r_en <= 1'b0;
      end
    end
  end

  // Prescaler: restarts from 0 on disable, on LOAD/CTRL writes and per tick.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b)                               r_pcnt <= '0;
    else if (!r_en || w_wr_load || w_wr_ctrl) r_pcnt <= '0;
    else if (w_tick)                           r_pcnt <= '0;
    else                                       r_pcnt <= r_pcnt + 8'd1;
  end

  // Down-counter: LOAD write first, then decrement or periodic reload.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b)                 r_value <= '0;
    else if (w_wr_load)          r_value <= apb.pwdata[CNT_WIDTH-1:0];
    else if (w_tick) begin
      if (r_value != '0)         r_value <= r_value - CNT_WIDTH'(1);
      else if (!r_oneshot)       r_value <= r_load;
    end
  end

  // Raw interrupt: an expiry on the same edge as INTCLR keeps it set.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b)          r_int_raw <= 1'b0;
    else if (w_expire)    r_int_raw <= 1'b1;
    else if (w_wr_intclr) r_int_raw <= 1'b0;
  end

  assign apb.prdata = r_prdata;
  assign tim_int    = r_int_raw & r_ie;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: zero-wait APB transfers, hand-computed
// expected register and interrupt values at known cycle offsets.
module tb_apb_timer_slave;
  logic hclk = 1'b0;
  logic hrst_b = 1'b0;
  logic tim_int;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] d;

  localparam logic [11:0] A_LOAD = 12'h000, A_VAL = 12'h004, A_CTRL = 12'h008,
                          A_CLR  = 12'h00C, A_STAT = 12'h010, A_UNM = 12'h020;

  apb_timer_slave_if bus ();

  apb_timer_slave #(.CNT_WIDTH(32)) dut (
    .hclk    (hclk),
    .hrst_b  (hrst_b),
    .apb     (bus.slave),
    .tim_int (tim_int)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle; returns 1 time unit after the edge.
  task automatic cyc();
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  // Setup + access; the write commits on the edge following return.
  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = a; bus.pwdata = v;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
  endtask

  // Setup + access; data sampled in the access cycle.
  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    v = bus.prdata;
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    #23 hrst_b = 1'b1;

    // Reset state
    chk("rst_tim_int", {31'd0, tim_int}, 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    rd(A_LOAD, d); chk("rst_load", d, 32'd0);
    rd(A_VAL,  d); chk("rst_value", d, 32'd0);
    rd(A_CTRL, d); chk("rst_ctrl", d, 32'd0);
    rd(A_CLR,  d); chk("rst_intclr", d, 32'd0);
    rd(A_STAT, d); chk("rst_intstat", d, 32'd0);

    // Periodic: LOAD=3, EN|IE, PRESC=0; CTRL commits at edge E
    wr(A_LOAD, 32'd3);
    rd(A_LOAD, d); chk("load_rb", d, 32'd3);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin     // E .. E+3
      cyc(); chk("per_no_int", {31'd0, tim_int}, 32'd0);
    end
    cyc(); chk("per_int_E4", {31'd0, tim_int}, 32'd1);
    rd(A_VAL, d); chk("per_val_E6", d, 32'd2);   // captured at E+6
    rd(A_VAL, d); chk("per_val_E8", d, 32'd0);   // captured at E+8
    wr(A_CLR, 32'd0);                           // commits at E+11
    cyc(); chk("per_clr_drop", {31'd0, tim_int}, 32'd0);
    cyc(); chk("per_reassert", {31'd0, tim_int}, 32'd1);  // E+12
    wr(A_CTRL, 32'h0);
    wr(A_CLR, 32'd0);
    cyc();

    // One-shot, PRESC=3: ticks at E+4, E+8, expiry at E+12
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h0307);
    repeat (5) cyc();                           // E .. E+4
    rd(A_VAL, d); chk("os_val_E6", d, 32'd1);
    repeat (5) cyc();                           // E+7 .. E+11
    chk("os_no_int_E11", {31'd0, tim_int}, 32'd0);
    cyc(); chk("os_int_E12", {31'd0, tim_int}, 32'd1);
    rd(A_CTRL, d); chk("os_ctrl_rb", d, 32'h0306);
    repeat (10) cyc();
    rd(A_VAL, d);  chk("os_val_hold", d, 32'd0);
    rd(A_STAT, d); chk("os_stat", d, 32'h3);
    wr(A_CTRL, 32'h0);
    wr(A_CLR, 32'd0);
    cyc();

    // LOAD write on the expiring tick (E+4)
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    cyc(); cyc();
    wr(A_LOAD, 32'd7);
    cyc(); chk("col_load_noint", {31'd0, tim_int}, 32'd0);
    rd(A_VAL, d);  chk("col_load_val", d, 32'd6);   // 7 at E+4, 6 at E+5
    rd(A_STAT, d); chk("col_load_stat", d, 32'd0);
    wr(A_CTRL, 32'h0);
    wr(A_CLR, 32'd0);
    cyc();

    // INTCLR write on the expiring tick (E+4)
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    cyc(); cyc();
    wr(A_CLR, 32'd0);
    rd(A_STAT, d); chk("col_clr_stat", d, 32'h3);
    wr(A_CTRL, 32'h0);
    wr(A_CLR, 32'd0);
    cyc();

    // Unmapped offset
    wr(A_UNM, 32'hFFFF_FFFF);
    rd(A_UNM, d);  chk("unm_rd", d, 32'd0);
    rd(A_LOAD, d); chk("unm_load", d, 32'd3);
    rd(A_CTRL, d); chk("unm_ctrl", d, 32'd0);
    rd(A_STAT, d); chk("unm_stat", d, 32'd0);

    // IE masked expiry: LOAD=1, EN only, first expiry at E+2
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h1);
    repeat (4) cyc();
    chk("mask_tim_int", {31'd0, tim_int}, 32'd0);
    rd(A_STAT, d); chk("mask_stat", d, 32'h1);
    chk("mask_tim_int2", {31'd0, tim_int}, 32'd0);

    // Async reset mid-count with INT_RAW=1 and non-zero prdata
    wr(A_CTRL, 32'h5);
    cyc(); chk("pre_rst_int", {31'd0, tim_int}, 32'd1);
    rd(A_STAT, d); chk("pre_rst_prdata", d, 32'h3);
    #2 hrst_b = 1'b0;
    #1;
    chk("arst_tim_int", {31'd0, tim_int}, 32'd0);
    chk("arst_prdata", bus.prdata, 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #13 hrst_b = 1'b1;
    repeat (6) cyc();
    rd(A_VAL, d);  chk("post_rst_val", d, 32'd0);
    rd(A_CTRL, d); chk("post_rst_ctrl", d, 32'd0);
    rd(A_STAT, d); chk("post_rst_stat", d, 32'd0);
    cyc();
    chk("post_rst_int", {31'd0, tim_int}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
